ula_seq: RTL and testbench

Parametrised, handshaked successor of the 8-bit registered ALU, with one operation in flight at a time. Operands and opcode are captured on a valid/ready input handshake. Single-cycle ops (add, sub, invert, compare, logic) and an iterative shift-add multiply produce a registered result plus status flags. The result is presented on a valid/ready output handshake. The block sits between the operand register file and the result bus, replacing the decoder-plus-tristate result selection with a registered result mux.

---
 rtl/ula_pkg.sv | 35 +++
 rtl/ula_seq_if.sv | 31 +++
 rtl/ula_mul_seq.sv | 60 ++++++
 rtl/ula_seq.sv | 137 +++++++++++++
 tb/tb_ula_seq.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/ula_pkg.sv
// Shared definitions for the sequential ALU.
//   - 4-bit opcode encodings
//   - FSM state encoding
//   - bit positions of the packed status-flag bus
package ula_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_NOTA = 4'd2;
    localparam logic [3:0] OP_NOTB = 4'd3;
    localparam logic [3:0] OP_EQ   = 4'd4;
    localparam logic [3:0] OP_NE   = 4'd5;
    localparam logic [3:0] OP_GT   = 4'd6;
    localparam logic [3:0] OP_LT   = 4'd7;
    localparam logic [3:0] OP_AND  = 4'd8;
    localparam logic [3:0] OP_OR   = 4'd9;
    localparam logic [3:0] OP_XOR  = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int FLAG_C    = 0;
    localparam int FLAG_Z    = 1;
    localparam int FLAG_V    = 2;
    localparam int FLAG_ERR  = 3;
    localparam int NUM_FLAGS = 4;

    typedef logic [NUM_FLAGS-1:0] flags_t;

endpackage

// File: rtl/ula_seq_if.sv
// Operand / result handshake bundle of the sequential ALU.
//   master : operand source and result consumer (drives in_valid, a, b,
//            opcode, out_ready)
//   slave  : the ALU itself (drives in_ready, out_valid, result, flags)
interface ula_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       opcode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_c;
    logic             flag_z;
    logic             flag_v;
    logic             flag_err;

    modport master (
        output in_valid, a, b, opcode, out_ready,
        input  in_ready, out_valid, result, flag_c, flag_z, flag_v, flag_err
    );

    modport slave (
        input  in_valid, a, b, opcode, out_ready,
        output in_ready, out_valid, result, flag_c, flag_z, flag_v, flag_err
    );

endinterface

// File: rtl/ula_mul_seq.sv
// Iterative shift-add multiplier, one partial product per clock.
//   ck, rst_n : clock, synchronous active-low reset (aborts a running multiply)
//   start     : load a/b and begin; a/b are sampled only on this cycle
//   a, b      : WIDTH-bit unsigned operands
//   done      : high during the cycle whose edge applies the final step
//   product   : full 2*WIDTH-bit product, valid while done is high
module ula_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               ck,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic               busy_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [2*WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0]   mplier_reg;
    logic [2*WIDTH-1:0] acc_next;

    assign acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

    // done is raised one step early and product taken from acc_next, so the
    // caller captures the finished product on the same edge the counter
    // reaches WIDTH; this keeps the multiply latency at exactly WIDTH edges.
    assign done    = busy_reg && (cnt_reg == CNT_W'(WIDTH - 1));
    assign product = acc_next;

    always_ff @(posedge ck) begin
        if (!rst_n) begin
            busy_reg   <= 1'b0;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
        end else if (start) begin
            busy_reg   <= 1'b1;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            mcand_reg  <= {{WIDTH{1'b0}}, a};
            mplier_reg <= b;
        end else if (busy_reg) begin
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            cnt_reg    <= cnt_reg + 1'b1;
            if (done) begin
                busy_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ula_seq.sv
// Handshaked sequential ALU, one operation in flight.
//   ck, rst_n : clock, synchronous active-low reset
//   bus       : ula_seq_if.slave
//               in_valid/in_ready + a, b, opcode   : operation accept
//               out_valid/out_ready + result, flags : registered result
// Single-cycle ops finish one edge after accept, MUL after WIDTH edges,
// illegal opcodes finish like single-cycle ops with flag_err set.
module ula_seq
    import ula_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic     ck,
    input  logic     rst_n,
    ula_seq_if.slave bus
);

    state_t             state_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [3:0]         op_reg;
    logic [WIDTH-1:0]   result_reg;
    flags_t             flags_reg;

    logic               accept;
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    logic [WIDTH:0]     sum_ext;
    logic [WIDTH:0]     diff_ext;
    logic [WIDTH-1:0]   calc_result;
    flags_t             calc_flags;

    assign accept    = bus.in_valid && (state_reg == IDLE);
    // Multiplier is fed straight from the bus so its first step lands on
    // the edge after accept.
    assign mul_start = accept && (bus.opcode == OP_MUL);

    ula_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .ck      (ck),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (bus.a),
        .b       (bus.b),
        .done    (mul_done),
        .product (mul_product)
    );

    // Single-cycle datapath working on the latched operands.
    always_comb begin
        sum_ext     = {1'b0, a_reg} + {1'b0, b_reg};
        diff_ext    = {1'b0, a_reg} - {1'b0, b_reg};
        calc_result = '0;
        calc_flags  = '0;
        case (op_reg)
            OP_ADD: begin
                calc_result        = sum_ext[WIDTH-1:0];
                calc_flags[FLAG_C] = sum_ext[WIDTH];
                // Same-sign operands producing an opposite-sign sum.
                calc_flags[FLAG_V] = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                     (sum_ext[WIDTH-1] != a_reg[WIDTH-1]);
            end
            OP_SUB: begin
                calc_result        = diff_ext[WIDTH-1:0];
                calc_flags[FLAG_C] = diff_ext[WIDTH];   // borrow, i.e. a < b
                calc_flags[FLAG_V] = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                                     (diff_ext[WIDTH-1] != a_reg[WIDTH-1]);
            end
            OP_NOTA: calc_result = ~a_reg;
            OP_NOTB: calc_result = ~b_reg;
            OP_EQ:   calc_result = WIDTH'(a_reg == b_reg);
            OP_NE:   calc_result = WIDTH'(a_reg != b_reg);
            OP_GT:   calc_result = WIDTH'(a_reg >  b_reg);
            OP_LT:   calc_result = WIDTH'(a_reg <  b_reg);
            OP_AND:  calc_result = a_reg & b_reg;
            OP_OR:   calc_result = a_reg | b_reg;
            OP_XOR:  calc_result = a_reg ^ b_reg;
            OP_MUL:  calc_result = '0;   // routed to MUL state, never computed here
            default: calc_flags[FLAG_ERR] = 1'b1;
        endcase
        calc_flags[FLAG_Z] = (calc_result == '0);
    end

    always_ff @(posedge ck) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            op_reg     <= '0;
            result_reg <= '0;
            flags_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        a_reg     <= bus.a;
                        b_reg     <= bus.b;
                        op_reg    <= bus.opcode;
                        state_reg <= (bus.opcode == OP_MUL) ? MUL : CALC;
                    end
                end
                CALC: begin
                    result_reg <= calc_result;
                    flags_reg  <= calc_flags;
                    state_reg  <= DONE;
                end
                MUL: begin
                    if (mul_done) begin
                        result_reg          <= mul_product[WIDTH-1:0];
                        flags_reg           <= '0;
                        flags_reg[FLAG_C]   <= |mul_product[2*WIDTH-1:WIDTH];
                        flags_reg[FLAG_Z]   <= (mul_product[WIDTH-1:0] == '0);
                        state_reg           <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.result    = result_reg;
    assign bus.flag_c    = flags_reg[FLAG_C];
    assign bus.flag_z    = flags_reg[FLAG_Z];
    assign bus.flag_v    = flags_reg[FLAG_V];
    assign bus.flag_err  = flags_reg[FLAG_ERR];

endmodule

// File: tb/tb_ula_seq.sv
// Directed bench for ula_seq (WIDTH=8): expected results come from an
// integer reference model, are queued when an operation is driven and
// popped when the DUT presents its result.
module tb_ula_seq;
    import ula_pkg::*;

    localparam int W = 8;

    logic ck    = 1'b0;
    logic rst_n = 1'b0;
    always #5 ck = ~ck;

    ula_seq_if #(.WIDTH(W)) bus ();

    ula_seq #(.WIDTH(W)) dut (
        .ck    (ck),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [W-1:0] result;
        logic         c;
        logic         z;
        logic         v;
        logic         err;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference model using plain integer arithmetic.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [3:0] op);
        exp_t e;
        int ua, ub, sa, sb_, r, sr;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb_ = int'($signed(b));
        r = 0;
        e.c = 0; e.v = 0; e.err = 0; e.lat = 1;
        case (op)
            4'd0: begin
                r = ua + ub; e.c = (r > 255);
                sr = sa + sb_; e.v = (sr > 127) || (sr < -128);
            end
            4'd1: begin
                r = ua - ub; e.c = (ua < ub);
                sr = sa - sb_; e.v = (sr > 127) || (sr < -128);
            end
            4'd2:  r = 255 - ua;
            4'd3:  r = 255 - ub;
            4'd4:  r = (ua == ub) ? 1 : 0;
            4'd5:  r = (ua != ub) ? 1 : 0;
            4'd6:  r = (ua >  ub) ? 1 : 0;
            4'd7:  r = (ua <  ub) ? 1 : 0;
            4'd8:  r = ua & ub;
            4'd9:  r = ua | ub;
            4'd10: r = ua ^ ub;
            4'd11: begin
                r = ua * ub; e.c = (r > 255); e.lat = W;
            end
            default: begin
                r = 0; e.err = 1;
            end
        endcase
        r = r & 255;
        e.result = W'(r);
        e.z = (r == 0);
        return e;
    endfunction

    // Wait (bounded) for out_valid; returns edges counted since the caller's point.
    task automatic wait_out(output int lat);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 200) begin
            @(posedge ck); #1;
            lat++;
        end
    endtask

    task automatic check_out(input exp_t e, input string nm);
        chk({nm, " result"}, bus.result,   e.result);
        chk({nm, " flag_c"}, bus.flag_c,   e.c);
        chk({nm, " flag_z"}, bus.flag_z,   e.z);
        chk({nm, " flag_v"}, bus.flag_v,   e.v);
        chk({nm, " flag_err"}, bus.flag_err, e.err);
    endtask

    task automatic release_out(input string nm);
        @(negedge ck);
        bus.out_ready = 1'b1;
        @(posedge ck); #1;
        bus.out_ready = 1'b0;
        chk({nm, " out_valid after handshake"}, bus.out_valid, 1'b0);
        chk({nm, " in_ready after handshake"},  bus.in_ready,  1'b1);
    endtask

    task automatic accept_op(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [3:0] op, input string nm);
        @(negedge ck);
        chk({nm, " in_ready before accept"}, bus.in_ready, 1'b1);
        bus.a = a; bus.b = b; bus.opcode = op; bus.in_valid = 1'b1;
        @(posedge ck); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
        exp_t  e;
        int    lat;
        string nm;
        nm = $sformatf("op%0d a=%0h b=%0h", op, a, b);
        sb.push_back(model(a, b, op));
        accept_op(a, b, op, nm);
        wait_out(lat);
        e = sb.pop_front();
        chk({nm, " latency"}, lat, e.lat);
        check_out(e, nm);
        $display("[TB] op=%0d a=%02h b=%02h -> result=%02h c=%0b z=%0b v=%0b err=%0b lat=%0d",
                 op, a, b, bus.result, bus.flag_c, bus.flag_z, bus.flag_v, bus.flag_err, lat);
        release_out(nm);
    endtask

    initial begin
        exp_t e;
        int   lat;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.opcode    = '0;

        // Reset held for two edges, then released.
        repeat (2) @(posedge ck);
        @(negedge ck);
        rst_n = 1'b1;
        @(posedge ck); #1;
        chk("reset result",    bus.result,    '0);
        chk("reset flags",     {bus.flag_err, bus.flag_v, bus.flag_z, bus.flag_c}, 4'h0);
        chk("reset out_valid", bus.out_valid, 1'b0);
        chk("reset in_ready",  bus.in_ready,  1'b1);
        $display("[TB] reset released: in_ready=%0b out_valid=%0b", bus.in_ready, bus.out_valid);

        // Directed operations from the plan.
        run_op(8'd200, 8'd100, OP_ADD);
        run_op(8'd5,   8'd7,   OP_SUB);
        run_op(8'h80,  8'h01,  OP_SUB);
        run_op(8'h80,  8'h7F,  OP_GT);
        run_op(8'h3C,  8'h3C,  OP_EQ);
        run_op(8'h7F,  8'h01,  OP_ADD);
        run_op(8'hA5,  8'h00,  OP_NOTA);
        run_op(8'h00,  8'hFF,  OP_NOTB);
        run_op(8'h12,  8'h12,  OP_NE);
        run_op(8'h01,  8'h02,  OP_LT);
        run_op(8'hF0,  8'h3C,  OP_AND);
        run_op(8'hF0,  8'h0F,  OP_OR);
        run_op(8'hAA,  8'hAA,  OP_XOR);
        run_op(8'd13,  8'd11,  OP_MUL);
        run_op(8'd16,  8'd16,  OP_MUL);
        run_op(8'hFF,  8'hFF,  OP_MUL);
        run_op(8'h00,  8'hFF,  OP_MUL);
        run_op(8'hFF,  8'hFF,  4'd15);
        run_op(8'h01,  8'h02,  4'd12);

        // Backpressure: result held, new request ignored while DONE.
        sb.push_back(model(8'h10, 8'h20, OP_ADD));
        accept_op(8'h10, 8'h20, OP_ADD, "bp");
        wait_out(lat);
        e = sb.pop_front();
        chk("bp latency", lat, e.lat);
        @(negedge ck);
        bus.a = 8'h01; bus.b = 8'h02; bus.opcode = OP_SUB; bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge ck); #1;
            chk($sformatf("bp hold%0d result", i),    bus.result,    e.result);
            chk($sformatf("bp hold%0d out_valid", i), bus.out_valid, 1'b1);
            chk($sformatf("bp hold%0d in_ready", i),  bus.in_ready,  1'b0);
        end
        check_out(e, "bp");
        $display("[TB] backpressure: result=%02h held 5 cycles", bus.result);
        @(negedge ck);
        bus.in_valid = 1'b0;
        release_out("bp");
        run_op(8'h5A, 8'h0F, OP_XOR);

        // Reset asserted on the third MUL edge discards the multiply.
        accept_op(8'd13, 8'd11, OP_MUL, "rstmul");
        repeat (2) @(posedge ck);
        @(negedge ck);
        rst_n = 1'b0;
        @(posedge ck); #1;
        rst_n = 1'b1;
        chk("rstmul out_valid", bus.out_valid, 1'b0);
        chk("rstmul result",    bus.result,    '0);
        chk("rstmul in_ready",  bus.in_ready,  1'b1);
        chk("rstmul flags",     {bus.flag_err, bus.flag_v, bus.flag_z, bus.flag_c}, 4'h0);
        $display("[TB] reset mid-multiply: out_valid=%0b in_ready=%0b", bus.out_valid, bus.in_ready);
        run_op(8'd3, 8'd3, OP_MUL);

        // A handful of random operations, all opcodes including illegal ones.
        for (int i = 0; i < 12; i++) begin
            run_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
                   4'($urandom_range(0, 15)));
        end

        chk("scoreboard empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
